// File: rtl/tx_fifo_arbiter_if.sv
// Signal bundle between the two byte producers, the shared TX FIFO write port,
// and the arbiter's grant/statistics pins.
interface tx_fifo_arbiter_if;
  logic        a_valid;
  logic [7:0]  a_data;
  logic        a_last;
  logic        a_ready;
  logic        b_valid;
  logic [7:0]  b_data;
  logic        b_last;
  logic        b_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic [1:0]  grant;
  logic        stat_clr;
  logic [15:0] a_bytes;
  logic [15:0] b_bytes;

  // Arbiter side.
  modport master (
    input  a_valid, a_data, a_last, b_valid, b_data, b_last, fifo_full, stat_clr,
    output a_ready, b_ready, fifo_wr_en, fifo_din, grant, a_bytes, b_bytes
  );

  // Environment side: producers, FIFO and statistics reader.
  modport slave (
    output a_valid, a_data, a_last, b_valid, b_data, b_last, fifo_full, stat_clr,
    input  a_ready, b_ready, fifo_wr_en, fifo_din, grant, a_bytes, b_bytes
  );
endinterface

// File: rtl/tx_fifo_arbiter.sv
// Round-robin write-side arbiter sharing one TX byte FIFO between producers A
// and B; a grant lasts one packet, capped by MAX_BURST and an idle TIMEOUT.
module tx_fifo_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  tx_fifo_arbiter_if.master bus
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_END = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDLE_END  = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t        state;
  logic          last_b;      // 1: B was served last, so A wins the next tie
  logic [BW-1:0] burst_cnt;
  logic [IW-1:0] idle_cnt;
  logic [15:0]   a_bytes_q;
  logic [15:0]   b_bytes_q;

  logic       sel_a;
  logic       sel_b;
  logic       cur_valid;
  logic       cur_last;
  logic [7:0] cur_data;
  logic       a_xfer;
  logic       b_xfer;
  logic       xfer;
  logic       release_now;

  // NOTE: every always_comb target gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    sel_a     = (state == GRANT_A);
    sel_b     = (state == GRANT_B);
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = 8'h00;
    if (sel_a) begin
      cur_valid = bus.a_valid;
      cur_last  = bus.a_last;
      cur_data  = bus.a_data;
    end else if (sel_b) begin
      cur_valid = bus.b_valid;
      cur_last  = bus.b_last;
      cur_data  = bus.b_data;
    end
    a_xfer = sel_a & bus.a_valid & ~bus.fifo_full;
    b_xfer = sel_b & bus.b_valid & ~bus.fifo_full;
    xfer   = a_xfer | b_xfer;
    // A blocked-but-valid owner never times out; only a low valid advances idle_cnt.
    release_now = (xfer & (cur_last | (burst_cnt == BURST_END)))
                | ((sel_a | sel_b) & ~cur_valid & (idle_cnt == IDLE_END));
  end

  assign bus.a_ready    = sel_a & ~bus.fifo_full;
  assign bus.b_ready    = sel_b & ~bus.fifo_full;
  assign bus.fifo_wr_en = xfer;
  assign bus.fifo_din   = xfer ? cur_data : 8'h00;
  assign bus.grant      = {sel_b, sel_a};
  assign bus.a_bytes    = a_bytes_q;
  assign bus.b_bytes    = b_bytes_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          burst_cnt <= '0;
          idle_cnt  <= '0;
          if (bus.a_valid && (!bus.b_valid || last_b)) begin
            state <= GRANT_A;
          end else if (bus.b_valid) begin
            state <= GRANT_B;
          end
        end
        GRANT_A, GRANT_B: begin
          if (release_now) begin
            state  <= IDLE;
            last_b <= (state == GRANT_B);
          end else if (xfer) begin
            burst_cnt <= burst_cnt + BW'(1);
            idle_cnt  <= '0;
          end else if (!cur_valid) begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating per-requester byte counters; a concurrent clear beats the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_bytes_q <= 16'h0000;
      b_bytes_q <= 16'h0000;
    end else if (bus.stat_clr) begin
      a_bytes_q <= 16'h0000;
      b_bytes_q <= 16'h0000;
    end else begin
      if (a_xfer && (a_bytes_q != 16'hFFFF)) a_bytes_q <= a_bytes_q + 16'd1;
      if (b_xfer && (b_bytes_q != 16'hFFFF)) b_bytes_q <= b_bytes_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// Directed bench for tx_fifo_arbiter: queue-fed producers, a write monitor and
// an optional 64-entry FIFO occupancy model; one task per scenario.
module tb_tx_fifo_arbiter;

  typedef struct {
    logic [7:0]  d;
    logic [1:0]  g;
    int          c;
    logic [15:0] ab;
    logic [15:0] bb;
  } wr_t;

  logic clk;
  logic rst;

  tx_fifo_arbiter_if bus ();

  tx_fifo_arbiter #(.MAX_BURST(8), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [8:0] a_q[$];
  logic [8:0] b_q[$];
  wr_t        wr_log[$];
  logic [1:0] g_at[int];
  int         a_rise = -1;
  logic       a_prev = 1'b0;
  logic       a_fire = 1'b0;
  logic       b_fire = 1'b0;
  logic       wr_pend = 1'b0;
  logic       model_en = 1'b0;
  logic       full_hold = 1'b0;
  logic       ovf = 1'b0;
  int         fifo_cnt = 0;

  assign bus.fifo_full = full_hold | (model_en & (fifo_cnt >= 64));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive_inputs();
    if (a_q.size() > 0) begin
      bus.a_valid = 1'b1; bus.a_data = a_q[0][7:0]; bus.a_last = a_q[0][8];
    end else begin
      bus.a_valid = 1'b0; bus.a_data = 8'h00; bus.a_last = 1'b0;
    end
    if (b_q.size() > 0) begin
      bus.b_valid = 1'b1; bus.b_data = b_q[0][7:0]; bus.b_last = b_q[0][8];
    end else begin
      bus.b_valid = 1'b0; bus.b_data = 8'h00; bus.b_last = 1'b0;
    end
  endtask

  // Producers and FIFO occupancy: update 1 time unit after each rising edge.
  initial begin
    drive_inputs();
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (wr_pend && model_en) fifo_cnt++;
      wr_pend = 1'b0;
      if (a_fire && a_q.size() > 0) a_q.delete(0);
      if (b_fire && b_q.size() > 0) b_q.delete(0);
      a_fire = 1'b0;
      b_fire = 1'b0;
      drive_inputs();
    end
  end

  // Monitor: samples on the falling edge, when all inputs and outputs are stable.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      a_fire  = bus.a_valid & bus.a_ready;
      b_fire  = bus.b_valid & bus.b_ready;
      wr_pend = bus.fifo_wr_en;
      g_at[cyc] = bus.grant;
      if (bus.a_valid && !a_prev) a_rise = cyc;
      a_prev = bus.a_valid;
      if (bus.fifo_wr_en) begin
        if (model_en && fifo_cnt >= 64) ovf = 1'b1;
        e.d  = bus.fifo_din;
        e.g  = bus.grant;
        e.c  = cyc;
        e.ab = bus.a_bytes;
        e.bb = bus.b_bytes;
        wr_log.push_back(e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic wait_writes(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (wr_log.size() < n && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    checks++;
    if (wr_log.size() < n) begin
      errors++;
      $display("FAIL %s: writes seen=%0d, required at least %0d", name, wr_log.size(), n);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    a_q.delete();
    b_q.delete();
    full_hold    = 1'b0;
    model_en     = 1'b0;
    bus.stat_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    fifo_cnt = 0;
    ovf      = 1'b0;
    wr_log.delete();
  endtask

  task automatic test_reset();
    logic [7:0] exp_d[3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.grant, bus.a_ready, bus.b_ready, bus.fifo_wr_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: grant=%b a_ready=%b b_ready=%b wr_en=%b, required all 0",
               bus.grant, bus.a_ready, bus.b_ready, bus.fifo_wr_en);
    end
    checks++;
    if (bus.fifo_din !== 8'h00 || bus.a_bytes !== 16'h0 || bus.b_bytes !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: din=%h a_bytes=%h b_bytes=%h, required 0",
               bus.fifo_din, bus.a_bytes, bus.b_bytes);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) a_q.push_back({1'b0, 8'hC0 + 8'(i)});
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.grant !== 2'b01 || bus.a_bytes === 16'h0) begin
      errors++;
      $display("FAIL pre_reset_burst: grant=%b a_bytes=%h, required 01 and nonzero",
               bus.grant, bus.a_bytes);
    end
    // Asynchronous reset mid-burst: outputs must drop before any clock edge.
    #2;
    rst = 1'b1;
    a_q.delete();
    #1;
    checks++;
    if ({bus.grant, bus.a_ready, bus.b_ready, bus.fifo_wr_en} !== 5'b0 ||
        bus.fifo_din !== 8'h00 || bus.a_bytes !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: grant=%b a_ready=%b wr_en=%b din=%h a_bytes=%h, required 0",
               bus.grant, bus.a_ready, bus.fifo_wr_en, bus.fifo_din, bus.a_bytes);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr_log.delete();
    a_q.push_back(9'h011);
    a_q.push_back(9'h022);
    a_q.push_back(9'h133);
    wait_writes(3, 20, "reset_pkt_wait");
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (wr_log.size() != 3) begin
      errors++;
      $display("FAIL reset_pkt_count: writes=%0d, required 3", wr_log.size());
    end
    checks++;
    if (g_at[a_rise] !== 2'b00) begin
      errors++;
      $display("FAIL reset_pkt_req_cycle: grant=%b, required 00", g_at[a_rise]);
    end
    for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
      checks++;
      if (wr_log[i].d !== exp_d[i] || wr_log[i].g !== 2'b01 || wr_log[i].c != a_rise + 1 + i) begin
        errors++;
        $display("FAIL reset_pkt_byte%0d: d=%h g=%b cyc=%0d, required d=%h g=01 cyc=%0d",
                 i, wr_log[i].d, wr_log[i].g, wr_log[i].c, exp_d[i], a_rise + 1 + i);
      end
    end
  endtask

  task automatic test_round_robin();
    int c0;
    int pr;
    logic [7:0] ed;
    logic [1:0] eg;
    apply_reset();
    for (int p = 0; p < 4; p++) begin
      a_q.push_back({1'b0, 8'hA0 + 8'(2 * p)});
      a_q.push_back({1'b1, 8'hA1 + 8'(2 * p)});
      b_q.push_back({1'b0, 8'hB0 + 8'(2 * p)});
      b_q.push_back({1'b1, 8'hB1 + 8'(2 * p)});
    end
    wait_writes(16, 60, "rr_wait");
    if (wr_log.size() < 16) return;
    c0 = wr_log[0].c;
    checks++;
    if (c0 != a_rise + 1) begin
      errors++;
      $display("FAIL rr_latency: first write cyc=%0d, required %0d", c0, a_rise + 1);
    end
    checks++;
    if (g_at[c0 + 2] !== 2'b00) begin
      errors++;
      $display("FAIL rr_dead_cycle: grant=%b, required 00", g_at[c0 + 2]);
    end
    // Grant k (0..7) alternates A,B; each holds 2 cycles then one IDLE cycle.
    for (int i = 0; i < 16; i++) begin
      pr = i / 2;
      ed = ((pr % 2 == 0) ? 8'hA0 : 8'hB0) + 8'(2 * (pr / 2) + (i % 2));
      eg = (pr % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (wr_log[i].d !== ed || wr_log[i].g !== eg || wr_log[i].c != c0 + 3 * pr + (i % 2)) begin
        errors++;
        $display("FAIL rr_write%0d: d=%h g=%b cyc=%0d, required d=%h g=%b cyc=%0d",
                 i, wr_log[i].d, wr_log[i].g, wr_log[i].c, ed, eg, c0 + 3 * pr + (i % 2));
      end
      if (i % 4 == 0) begin
        checks++;
        if (wr_log[i].ab !== 16'(2 * (i / 4)) || wr_log[i].bb !== 16'(2 * (i / 4))) begin
          errors++;
          $display("FAIL rr_stats_pair%0d: a_bytes=%0d b_bytes=%0d, required both %0d",
                   i / 4, wr_log[i].ab, wr_log[i].bb, 2 * (i / 4));
        end
      end
    end
  endtask

  task automatic test_burst_cap();
    logic [7:0] exp_d[$];
    logic [1:0] exp_g[$];
    apply_reset();
    for (int i = 0; i < 20; i++) a_q.push_back({1'b0, 8'(i + 1)});
    b_q.push_back(9'h0B1);
    b_q.push_back(9'h1B2);
    // A 1..8, B B1 B2, A 9..16, then A alone again for 17..20.
    for (int i = 1; i <= 8; i++) begin exp_d.push_back(8'(i)); exp_g.push_back(2'b01); end
    exp_d.push_back(8'hB1); exp_g.push_back(2'b10);
    exp_d.push_back(8'hB2); exp_g.push_back(2'b10);
    for (int i = 9; i <= 20; i++) begin exp_d.push_back(8'(i)); exp_g.push_back(2'b01); end
    wait_writes(22, 80, "burst_wait");
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if (wr_log.size() != 22) begin
      errors++;
      $display("FAIL burst_count: writes=%0d, required 22", wr_log.size());
    end
    for (int i = 0; i < 22 && i < wr_log.size(); i++) begin
      checks++;
      if (wr_log[i].d !== exp_d[i] || wr_log[i].g !== exp_g[i]) begin
        errors++;
        $display("FAIL burst_write%0d: d=%h g=%b, required d=%h g=%b",
                 i, wr_log[i].d, wr_log[i].g, exp_d[i], exp_g[i]);
      end
    end
    checks++;
    if (bus.a_bytes !== 16'd20 || bus.b_bytes !== 16'd2) begin
      errors++;
      $display("FAIL burst_stats: a_bytes=%0d b_bytes=%0d, required 20 and 2", bus.a_bytes, bus.b_bytes);
    end
  endtask

  task automatic test_backpressure();
    int c_third;
    apply_reset();
    for (int i = 0; i < 10; i++) a_q.push_back({(i == 9), 8'h40 + 8'(i)});
    wait_writes(3, 20, "bp_wait_start");
    c_third = (wr_log.size() >= 3) ? wr_log[2].c : 0;
    full_hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.a_ready !== 1'b0 || bus.fifo_wr_en !== 1'b0 || bus.grant !== 2'b01 || bus.fifo_din !== 8'h00) begin
        errors++;
        $display("FAIL bp_hold%0d: a_ready=%b wr_en=%b grant=%b din=%h, required 0 0 01 00",
                 k, bus.a_ready, bus.fifo_wr_en, bus.grant, bus.fifo_din);
      end
      @(posedge clk); #2;
    end
    full_hold = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 8'h43 || bus.a_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_resume: wr_en=%b din=%h a_ready=%b, required 1 43 1",
               bus.fifo_wr_en, bus.fifo_din, bus.a_ready);
    end
    wait_writes(10, 30, "bp_wait_end");
    for (int i = 0; i < 10 && i < wr_log.size(); i++) begin
      checks++;
      if (wr_log[i].d !== 8'h40 + 8'(i) || (i == 3 && wr_log[i].c != c_third + 6)) begin
        errors++;
        $display("FAIL bp_write%0d: d=%h cyc=%0d, required d=%h", i, wr_log[i].d, wr_log[i].c, 8'h40 + 8'(i));
      end
    end

    // Occupancy model: the 64-entry FIFO fills, the owner stalls, nothing overflows.
    apply_reset();
    model_en = 1'b1;
    for (int i = 0; i < 70; i++) a_q.push_back({(i % 7 == 6), 8'(i)});
    repeat (100) @(posedge clk);
    @(negedge clk);
    checks++;
    if (fifo_cnt != 64 || ovf !== 1'b0 || wr_log.size() != 64) begin
      errors++;
      $display("FAIL fifo_fill: count=%0d overflow=%b writes=%0d, required 64 0 64", fifo_cnt, ovf, wr_log.size());
    end
    checks++;
    if (bus.grant !== 2'b01 || bus.a_ready !== 1'b0 || bus.fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full_stall: grant=%b a_ready=%b wr_en=%b, required 01 0 0",
               bus.grant, bus.a_ready, bus.fifo_wr_en);
    end
    model_en = 1'b0;
    wait_writes(70, 40, "fifo_drain");
    for (int i = 0; i < 70 && i < wr_log.size(); i++) begin
      if (wr_log[i].d !== 8'(i)) begin
        checks++;
        errors++;
        $display("FAIL fifo_order%0d: d=%h, required %h", i, wr_log[i].d, 8'(i));
        break;
      end
    end
  endtask

  task automatic test_timeout();
    int c;
    apply_reset();
    a_q.push_back(9'h05A);
    b_q.push_back(9'h15B);
    wait_writes(2, 30, "to_wait");
    if (wr_log.size() < 2) return;
    c = wr_log[0].c;
    checks++;
    if (wr_log[0].d !== 8'h5A || wr_log[0].g !== 2'b01) begin
      errors++;
      $display("FAIL to_first: d=%h g=%b, required 5A 01", wr_log[0].d, wr_log[0].g);
    end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (g_at[c + k] !== 2'b01) begin
        errors++;
        $display("FAIL to_hold%0d: grant=%b, required 01", k, g_at[c + k]);
      end
    end
    checks++;
    if (g_at[c + 5] !== 2'b00) begin
      errors++;
      $display("FAIL to_release: grant=%b, required 00", g_at[c + 5]);
    end
    checks++;
    if (wr_log[1].d !== 8'h5B || wr_log[1].g !== 2'b10 || wr_log[1].c != c + 6) begin
      errors++;
      $display("FAIL to_b_grant: d=%h g=%b cyc=%0d, required 5B 10 cyc=%0d",
               wr_log[1].d, wr_log[1].g, wr_log[1].c, c + 6);
    end
  endtask

  task automatic test_stats();
    int k;
    apply_reset();
    @(negedge clk);
    force dut.a_bytes_q = 16'hFFFE;
    #1;
    release dut.a_bytes_q;
    #1;
    checks++;
    if (bus.a_bytes !== 16'hFFFE) begin
      errors++;
      $display("FAIL stat_preload: a_bytes=%h, required FFFE", bus.a_bytes);
    end
    a_q.push_back(9'h001);
    a_q.push_back(9'h002);
    a_q.push_back(9'h103);
    wait_writes(3, 20, "stat_wait");
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (bus.a_bytes !== 16'hFFFF) begin
      errors++;
      $display("FAIL stat_saturate: a_bytes=%h, required FFFF", bus.a_bytes);
    end
    wr_log.delete();
    for (int i = 0; i < 4; i++) a_q.push_back({(i == 3), 8'h70 + 8'(i)});
    k = 0;
    @(negedge clk);
    while (!bus.fifo_wr_en && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!bus.fifo_wr_en) begin
      errors++;
      $display("FAIL stat_clr_wait: no write within 20 cycles");
    end
    bus.stat_clr = 1'b1;
    @(posedge clk); #1;
    bus.stat_clr = 1'b0;
    checks++;
    if (bus.a_bytes !== 16'h0 || bus.b_bytes !== 16'h0) begin
      errors++;
      $display("FAIL stat_clr_wins: a_bytes=%h b_bytes=%h, required 0", bus.a_bytes, bus.b_bytes);
    end
    wait_writes(4, 20, "stat_clr_drain");
    @(posedge clk); #2;
    checks++;
    if (bus.a_bytes !== 16'd3) begin
      errors++;
      $display("FAIL stat_after_clr: a_bytes=%0d, required 3", bus.a_bytes);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.stat_clr = 1'b0;
    test_reset();
    test_round_robin();
    test_burst_cap();
    test_backpressure();
    test_timeout();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_fifo_arbiter.md
# tx_fifo_arbiter

Write-side arbiter that shares the single 64-entry byte FIFO of the buffered UART transmit path between two byte producers, A and B. Round-robin grants are held for one packet, bounded by a maximum burst length and an idle timeout, so neither source can starve the other. It drives the FIFO write port directly (wr_en / buf_in), honours its full flag, and keeps per-requester byte statistics.

## Interface
- MAX_BURST, 8: max bytes accepted per grant (≥1)
- TIMEOUT, 4: consecutive granted cycles with valid low before the grant is released (≥1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- a_valid  in  1  requester A has a byte
- a_data  in  8  requester A byte
- a_last  in  1  byte on a_data ends A's packet
- a_ready  out  1  A byte accepted this cycle when a_valid & a_ready
- b_valid, b_data, b_last, b_ready  as A, for requester B
- fifo_full  in  1  FIFO full flag (buf_full)
- fifo_wr_en  out  1  FIFO write enable (wr_en)
- fifo_din  out  8  FIFO write data (buf_in)
- grant  out  2  one-hot current owner {B,A}; 00 in IDLE
- stat_clr  in  1  synchronous clear of the byte counters
- a_bytes, b_bytes  out  16  saturating count of bytes written per requester

## Operation
- States: IDLE, GRANT_A, GRANT_B (registered). last_served register (A/B) resets to B, so A wins the first tie.
- IDLE: if exactly one valid, go to its GRANT. If both valid, go to the one ≠ last_served. If none, stay. On entry to GRANT: burst_cnt=0, idle_cnt=0.
- GRANT_x: x_ready = !fifo_full (combinational); other ready = 0. Transfer = x_valid & x_ready. fifo_wr_en = transfer, fifo_din = x_data (0 when no transfer).
- Per transfer: burst_cnt+1, idle_cnt cleared, x_bytes+1 (saturates at 0xFFFF).
- Cycle with x_valid low: idle_cnt+1. Cycle with x_valid high but blocked by fifo_full: idle_cnt holds. It does not time out.
- Release, i.e. go to IDLE and set last_served=x, when any of these occur:
  - a transfer with x_last=1;
  - a transfer with burst_cnt==MAX_BURST-1;
  - x_valid low with idle_cnt==TIMEOUT-1.
- Requester data must stay stable while valid & !ready. The arbiter never writes when fifo_full=1, so no FIFO overflow is possible.
- stat_clr zeroes both counters. If it coincides with a transfer, the clear wins.
- Reset (any time, including mid-burst): state IDLE, last_served=B, burst_cnt=idle_cnt=0, a_bytes=b_bytes=0. All outputs 0: grant, a_ready, b_ready, fifo_wr_en, fifo_din. A partial packet is abandoned. Bytes already written stay in the FIFO (reset separately).

## Timing
- Request latency: valid rising in IDLE in cycle n gives grant/ready in cycle n+1 (if !fifo_full), and the first write at the edge ending n+1.
- Throughput: 1 byte/cycle within a grant.
- Turnaround: the releasing transfer at the edge ending cycle k gives IDLE in k+1 and the next grant in k+2 (one dead cycle).
- fifo_full is sampled combinationally in the same cycle. The FIFO counter update at the write edge drives the next cycle's full.
- Timeout: valid low for TIMEOUT cycles gives IDLE in the following cycle.

## Test plan
- Reset then idle:
  - stimulus: assert rst mid-cycle with A mid-burst;
  - required: all outputs 0 immediately, grant=00, counters 0. After release, a 3-byte A packet 0x11,0x22,0x33 (last on 0x33) appears on fifo_din on 3 consecutive cycles starting 1 cycle after a_valid.
- Round-robin tie:
  - stimulus: A and B both continuously valid with 2-byte packets;
  - required: grant sequence A,B,A,B with one IDLE cycle between grants; a_bytes==b_bytes after each pair.
- Burst cap:
  - stimulus: MAX_BURST=8; A streams 20 bytes with no last while B is valid;
  - required: 8 A bytes, then B served, then A resumes at byte 9. No byte lost or duplicated.
- FIFO full backpressure:
  - stimulus: hold fifo_full=1 for 5 cycles mid-packet;
  - required: a_ready=0, fifo_wr_en=0, no timeout and grant kept, transfer resumes the cycle after full drops. With the real fifo the total count is 64 and no overflow occurs.
- Idle timeout:
  - stimulus: TIMEOUT=4; A sends 1 byte without last, then drops valid;
  - required: grant released after 4 low cycles; B (waiting) granted 1 cycle later.
- Statistics:
  - stimulus: preload a_bytes to 0xFFFE via traffic/force, send 3 bytes;
  - required: a_bytes=0xFFFF. stat_clr concurrent with a transfer gives 0.
